muldiv_ctrl: RTL and testbench

- Sequencing controller for the multiply/divide resource in the E stage of the pipelined MIPS core.
- Accepts a decoded `muldivop` from E-stage control and owns the HI/LO registers.
- Models the fixed multi-cycle latency of mult/div and drives the `start`/`busy` pair that the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo.
- Honours an exception flush so a cancelled instruction never touches HI/LO.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 22 ++
 rtl/muldiv_arith.sv | 48 ++++
 rtl/muldiv_ctrl.sv | 124 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the E-stage multiply/divide controller: op codes, FSM states and
// latency counter width.
package muldiv_pkg;

  localparam int unsigned CntW = 4;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// E-stage control/operand bundle into the multiply/divide controller and its HI/LO and
// stall outputs back to the pipeline and hazard unit.
interface muldiv_if;
  logic [3:0]  muldivop;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output muldivop, flush, a, b,
    input  start, busy, hi, lo
  );

  modport slave (
    input  muldivop, flush, a, b,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_arith.sv
// Single-cycle multiply/divide datapath; result is {hi, lo}. Kept apart from the sequencer so
// an iterative divider can replace it later.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        dz
);

  logic signed [63:0] sa, sb;
  logic        [63:0] ua, ub;
  logic signed [31:0] sq, sr;

  always_comb begin
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    sq  = '0;
    sr  = '0;
    res = '0;
    dz  = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
    case (op)
      MD_MULT, MD_MADD, MD_MSUB:    res = sa * sb;
      MD_MULTU, MD_MADDU, MD_MSUBU: res = ua * ub;
      MD_DIV: begin
        // The one signed overflow case is pinned down rather than left to the divider.
        if (b == '0) begin
          res = '0;
        end else if ((a == 32'h8000_0000) && (b == 32'hffff_ffff)) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          sq  = $signed(a) / $signed(b);
          sr  = $signed(a) % $signed(b);
          res = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b != '0) res = {a % b, a / b};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed mult/div latency and drives start/busy.
// Define MULDIV_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  localparam logic [CntW-1:0] MulCnt = CntW'(MUL_LAT);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_LAT);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [63:0]     pend;
  logic            pend_dz;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;
  logic [63:0]     arith_res;
  logic            arith_dz;
  logic            op_mul, op_div, op_mthi, op_mtlo, op_lat, issue;
  logic [63:0]     commit_val;
`ifdef MULDIV_MADD_EN
  logic [3:0]      pend_op;
`endif

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    case (md.muldivop)
      MD_MULT, MD_MULTU: op_mul  = 1'b1;
      MD_DIV, MD_DIVU:   op_div  = 1'b1;
      MD_MTHI:           op_mthi = 1'b1;
      MD_MTLO:           op_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: op_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign op_lat   = op_mul | op_div;
  assign issue    = (op_lat | op_mthi | op_mtlo) & ~md.flush & ~busy_q;
  assign md.start = issue & op_lat;
  assign md.busy  = busy_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

  muldiv_arith u_arith (
    .op  (md.muldivop),
    .a   (md.a),
    .b   (md.b),
    .res (arith_res),
    .dz  (arith_dz)
  );

  // Accumulating ops fold into whatever HI/LO hold at commit, not at issue.
  always_comb begin
    commit_val = pend;
`ifdef MULDIV_MADD_EN
    case (pend_op)
      MD_MADD, MD_MADDU: commit_val = {hi_q, lo_q} + pend;
      MD_MSUB, MD_MSUBU: commit_val = {hi_q, lo_q} - pend;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= StIdle;
      cnt     <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_MADD_EN
      pend_op <= MD_NONE;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (issue) begin
            if (op_lat) begin
              pend    <= arith_res;
              pend_dz <= arith_dz;
              cnt     <= op_div ? DivCnt : MulCnt;
              busy_q  <= 1'b1;
              state   <= StRun;
`ifdef MULDIV_MADD_EN
              pend_op <= md.muldivop;
`endif
            end else if (op_mthi) begin
              hi_q <= md.a;
            end else begin
              lo_q <= md.a;
            end
          end
        end
        StRun: begin
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) begin
            // Divide by zero still burns the full latency but leaves HI/LO alone.
            if (!pend_dz) begin
              hi_q <= commit_val[63:32];
              lo_q <= commit_val[31:0];
            end
            busy_q <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, arithmetic, div-by-zero, back-to-back issue, flush
// and mid-op reset, with hand-computed expectations.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_if bus ();

  muldiv_ctrl #(
    .MUL_LAT (5),
    .DIV_LAT (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic fl);
    bus.muldivop = op;
    bus.a        = av;
    bus.b        = bv;
    bus.flush    = fl;
    #1;
  endtask

  // Present op for one edge, checking the combinational start first.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic exp_start);
    present(op, av, bv, 1'b0);
    chk({tag, ".start"}, 32'(bus.start), 32'(exp_start));
    tick();
    bus.muldivop = MD_NONE;
  endtask

  task automatic wait_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    present(MD_NONE, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.hi", bus.hi, 32'h0);
    chk("rst.lo", bus.lo, 32'h0);
    chk("rst.start", 32'(bus.start), 32'd0);
    reset = 1'b1;
    tick();

    // -2 * 3 = -6
    issue("mult", MD_MULT, 32'hffff_fffe, 32'd3, 1'b1);
    chk("mult.start_drop", 32'(bus.start), 32'd0);
    chk("mult.busy_rise", 32'(bus.busy), 32'd1);
    chk("mult.lo_hold", bus.lo, 32'h0);
    wait_busy("mult", 5);
    chk("mult.hi", bus.hi, 32'hffff_ffff);
    chk("mult.lo", bus.lo, 32'hffff_fffa);

    issue("divu", MD_DIVU, 32'd100, 32'd7, 1'b1);
    wait_busy("divu", 10);
    chk("divu.hi", bus.hi, 32'd2);
    chk("divu.lo", bus.lo, 32'd14);

    // -7 / 2 = -3 rem -1
    issue("div", MD_DIV, 32'hffff_fff9, 32'd2, 1'b1);
    wait_busy("div", 10);
    chk("div.hi", bus.hi, 32'hffff_ffff);
    chk("div.lo", bus.lo, 32'hffff_fffd);

    issue("ovf", MD_DIV, 32'h8000_0000, 32'hffff_ffff, 1'b1);
    wait_busy("ovf", 10);
    chk("ovf.hi", bus.hi, 32'h0);
    chk("ovf.lo", bus.lo, 32'h8000_0000);

    issue("mthi", MD_MTHI, 32'h11, 32'h0, 1'b0);
    chk("mthi.busy", 32'(bus.busy), 32'd0);
    chk("mthi.hi", bus.hi, 32'h11);
    issue("mtlo", MD_MTLO, 32'h22, 32'h0, 1'b0);
    chk("mtlo.lo", bus.lo, 32'h22);
    chk("mtlo.hi", bus.hi, 32'h11);

    issue("dz", MD_DIV, 32'd5, 32'd0, 1'b1);
    wait_busy("dz", 10);
    chk("dz.hi", bus.hi, 32'h11);
    chk("dz.lo", bus.lo, 32'h22);

    // Back-to-back: second op issued in the first non-busy cycle.
    issue("b2b1", MD_MULT, 32'd6, 32'd7, 1'b1);
    wait_busy("b2b1", 5);
    chk("b2b1.hi", bus.hi, 32'h0);
    chk("b2b1.lo", bus.lo, 32'd42);
    issue("b2b2", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
    // Ops arriving while busy must be ignored.
    present(MD_MTHI, 32'hdead_beef, 32'h0, 1'b0);
    chk("busyop.start1", 32'(bus.start), 32'd0);
    tick();
    present(MD_MULT, 32'd9, 32'd9, 1'b0);
    chk("busyop.start2", 32'(bus.start), 32'd0);
    chk("busyop.hi_hold", bus.hi, 32'h0);
    chk("busyop.lo_hold", bus.lo, 32'd42);
    tick();
    bus.muldivop = MD_NONE;
    wait_busy("b2b2", 3);
    chk("b2b2.hi", bus.hi, 32'h1);
    chk("b2b2.lo", bus.lo, 32'h0);

    // Flush blocks issue.
    present(MD_MULTU, 32'd5, 32'd5, 1'b1);
    chk("flush.start", 32'(bus.start), 32'd0);
    tick();
    chk("flush.busy", 32'(bus.busy), 32'd0);
    chk("flush.hi", bus.hi, 32'h1);
    chk("flush.lo", bus.lo, 32'h0);
    present(MD_NONE, 32'h0, 32'h0, 1'b0);

    // Flush during RUN does not abort.
    issue("runfl", MD_MULTU, 32'hffff_ffff, 32'hffff_ffff, 1'b1);
    bus.flush = 1'b1;
    wait_busy("runfl", 5);
    bus.flush = 1'b0;
    chk("runfl.hi", bus.hi, 32'hffff_fffe);
    chk("runfl.lo", bus.lo, 32'h0000_0001);

    issue("unk", 4'd15, 32'd3, 32'd3, 1'b0);
    chk("unk.busy", 32'(bus.busy), 32'd0);
    chk("unk.lo", bus.lo, 32'h0000_0001);

`ifdef MULDIV_MADD_EN
    issue("madd.mthi", MD_MTHI, 32'h0, 32'h0, 1'b0);
    issue("madd.mtlo", MD_MTLO, 32'hffff_ffff, 32'h0, 1'b0);
    issue("madd", MD_MADD, 32'd1, 32'd1, 1'b1);
    wait_busy("madd", 5);
    chk("madd.hi", bus.hi, 32'h1);
    chk("madd.lo", bus.lo, 32'h0);
`else
    issue("madd_off", MD_MADD, 32'd1, 32'd1, 1'b0);
    chk("madd_off.busy", 32'(bus.busy), 32'd0);
    chk("madd_off.hi", bus.hi, 32'hffff_fffe);
    chk("madd_off.lo", bus.lo, 32'h0000_0001);
`endif

    // Reset in the third busy cycle of a div abandons it.
    issue("rstmid", MD_DIVU, 32'd100, 32'd7, 1'b1);
    tick();
    tick();
    chk("rstmid.busy3", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("rstmid.busy", 32'(bus.busy), 32'd0);
    chk("rstmid.hi", bus.hi, 32'h0);
    chk("rstmid.lo", bus.lo, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rstmid.busy_after", 32'(bus.busy), 32'd0);
    chk("rstmid.hi_after", bus.hi, 32'h0);
    chk("rstmid.lo_after", bus.lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
